// File: rtl/alarm_output_arbiter.sv
// Alarm output arbiter: shares the siren driver and status LED between
// the alarm FSM, a panic button and a lock/unlock chirp source.
//
// Priority is alarm > panic > chirp. A higher-priority request preempts a
// lower one on the same clock edge. All outputs are registered, so the
// response to a sampled request appears on the following clk edge.
//
// Optional feature macro: ALARM_PANIC_EN
//   defined     : panic_btn toggles a timed panic siren
//   not defined : panic_btn is ignored, PANIC is unreachable, grant[1]=0
//
// Parameters
//   T_PANIC     cycles the panic siren stays on if not cancelled
//   T_CHIRP_ON  cycles the siren is on per chirp
//   T_CHIRP_OFF cycles the siren is off between chirps
//   CNT_W       width of the shared phase counter
//
// Ports
//   clk         system clock (all timing is in clk cycles)
//   rst         synchronous reset, active-high
//   alarm_siren level, intrusion siren request from the alarm FSM
//   alarm_led   level, LED pattern from the alarm FSM (passed when idle)
//   panic_btn   1-cycle pulse, toggles panic
//   chirp_req   1-cycle pulse, start a chirp burst
//   chirp_num   chirps in the burst, sampled with chirp_req (0 = ignored)
//   siren       registered siren drive
//   led         registered LED drive
//   grant       one-hot owner {chirp,panic,alarm}, 000 when idle
//   chirp_busy  high while a burst is in progress
//   chirp_done  1-cycle pulse when a burst completes without abort

module alarm_output_arbiter #(
    parameter int T_PANIC     = 30,
    parameter int T_CHIRP_ON  = 1,
    parameter int T_CHIRP_OFF = 2,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_siren,
    input  logic       alarm_led,
    input  logic       panic_btn,
    input  logic       chirp_req,
    input  logic [1:0] chirp_num,
    output logic       siren,
    output logic       led,
    output logic [2:0] grant,
    output logic       chirp_busy,
    output logic       chirp_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALARM,
        S_PANIC,
        S_CHIRP_ON,
        S_CHIRP_OFF
    } state_t;

    // Terminal counts: the counter restarts from 0 on every state entry,
    // so a state lasting N cycles exits when it sees N-1.
    localparam logic [CNT_W-1:0] PANIC_LAST = CNT_W'(T_PANIC - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(T_CHIRP_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(T_CHIRP_OFF - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [1:0]       rem;
    logic [1:0]       rem_nx;

    logic             siren_nx;
    logic             led_nx;
    logic [2:0]       grant_nx;
    logic             busy_nx;
    logic             done_nx;

    logic             panic_ev;
    logic             chirp_ev;

`ifdef ALARM_PANIC_EN
    assign panic_ev = panic_btn;
`else
    logic unused_panic_btn;
    assign unused_panic_btn = panic_btn;
    assign panic_ev         = 1'b0;
`endif

    assign chirp_ev = chirp_req && (chirp_num != 2'd0);

    // Next-state logic. chirp_req is only honoured from IDLE, so a
    // request arriving while any other owner holds the siren is dropped.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        done_nx  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (alarm_siren) begin
                    state_nx = S_ALARM;
                end else if (panic_ev) begin
                    state_nx = S_PANIC;
                end else if (chirp_ev) begin
                    state_nx = S_CHIRP_ON;
                    rem_nx   = chirp_num;
                end
            end

            S_ALARM: begin
                if (!alarm_siren) begin
                    state_nx = S_IDLE;
                end
            end

            S_PANIC: begin
                if (alarm_siren) begin
                    state_nx = S_ALARM;
                end else if (panic_ev || cnt == PANIC_LAST) begin
                    state_nx = S_IDLE;
                end
            end

            S_CHIRP_ON: begin
                if (alarm_siren) begin
                    state_nx = S_ALARM;
                    rem_nx   = 2'd0;
                end else if (panic_ev) begin
                    state_nx = S_PANIC;
                    rem_nx   = 2'd0;
                end else if (cnt == ON_LAST) begin
                    rem_nx = rem - 2'd1;
                    if (rem == 2'd1) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = S_CHIRP_OFF;
                    end
                end
            end

            S_CHIRP_OFF: begin
                if (alarm_siren) begin
                    state_nx = S_ALARM;
                    rem_nx   = 2'd0;
                end else if (panic_ev) begin
                    state_nx = S_PANIC;
                    rem_nx   = 2'd0;
                end else if (cnt == OFF_LAST) begin
                    state_nx = S_CHIRP_ON;
                end
            end

            default: begin
                state_nx = S_IDLE;
                rem_nx   = 2'd0;
            end
        endcase
    end

    // Only the timed states count; ALARM and IDLE hold the counter at 0
    // so it can never wrap during an arbitrarily long alarm.
    always_comb begin
        cnt_nx = '0;
        if (state_nx == state) begin
            if (state == S_PANIC || state == S_CHIRP_ON ||
                state == S_CHIRP_OFF) begin
                cnt_nx = cnt + CNT_W'(1);
            end
        end
    end

    // Output decode from the next state so the registered outputs change
    // on the same edge as the state itself.
    always_comb begin
        siren_nx = 1'b0;
        led_nx   = alarm_led;
        grant_nx = 3'b000;
        busy_nx  = 1'b0;

        unique case (state_nx)
            S_IDLE: begin
                led_nx = alarm_led;
            end
            S_ALARM: begin
                siren_nx = 1'b1;
                led_nx   = 1'b1;
                grant_nx = 3'b001;
            end
            S_PANIC: begin
                siren_nx = 1'b1;
                led_nx   = 1'b1;
                grant_nx = 3'b010;
            end
            S_CHIRP_ON: begin
                siren_nx = 1'b1;
                led_nx   = 1'b1;
                grant_nx = 3'b100;
                busy_nx  = 1'b1;
            end
            S_CHIRP_OFF: begin
                led_nx   = alarm_led;
                grant_nx = 3'b100;
                busy_nx  = 1'b1;
            end
            default: begin
                led_nx = alarm_led;
            end
        endcase

`ifndef ALARM_PANIC_EN
        grant_nx[1] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rem        <= 2'd0;
            siren      <= 1'b0;
            led        <= 1'b0;
            grant      <= 3'b000;
            chirp_busy <= 1'b0;
            chirp_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            rem        <= rem_nx;
            siren      <= siren_nx;
            led        <= led_nx;
            grant      <= grant_nx;
            chirp_busy <= busy_nx;
            chirp_done <= done_nx;
        end
    end

endmodule
